// File: rtl/dca_matrix_rrow_assembler.sv
// Read-row assembler: queues descriptors, collects R beats into full rows, emits rows in order.
// Optional DCA_RROW_ASSEMBLER_ERROR_EN: rlast/rresp-driven row termination and error checking.
module dca_matrix_rrow_assembler #(
    parameter int unsigned BW_AXI_DATA      = 32,
    parameter int unsigned MAX_NUM_AXI_DATA = 4,
    parameter int unsigned BW_BITADDR       = 32,
    parameter int unsigned NUM_ENTRY        = 2,
    localparam int unsigned BW_ROW          = BW_AXI_DATA * MAX_NUM_AXI_DATA,
    localparam int unsigned BW_TXN_INFO     = 2 + 8 + BW_BITADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   txn_valid,
    input  logic [BW_TXN_INFO-1:0] txn_info,
    output logic                   txn_ready,
    input  logic                   rvalid,
    input  logic                   rlast,
    input  logic [1:0]             rresp,
    input  logic [BW_AXI_DATA-1:0] rdata,
    output logic                   rready,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [BW_ROW-1:0]      row_data,
    output logic [BW_TXN_INFO-1:0] row_info,
    output logic                   row_error
);

    localparam int unsigned PtrW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
    localparam int unsigned CntW = $clog2(NUM_ENTRY + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NUM_ENTRY - 1)) ? '0 : p + 1'b1;
    endfunction

    state_e            state_q;
    logic [BW_ROW-1:0] asm_q;
    logic [7:0]        beat_cnt_q;
    logic              err_q;

    logic [BW_TXN_INFO-1:0] desc_mem [NUM_ENTRY];
    logic [PtrW-1:0]        desc_wr_q, desc_rd_q;
    logic [CntW-1:0]        desc_cnt_q;

    logic [BW_ROW-1:0]      row_mem  [NUM_ENTRY];
    logic [BW_TXN_INFO-1:0] info_mem [NUM_ENTRY];
    logic [PtrW-1:0]        out_wr_q, out_rd_q;
    logic [CntW-1:0]        out_cnt_q;

    logic                   active;
    logic                   desc_empty, desc_full, out_empty, out_full;
    logic [BW_TXN_INFO-1:0] head_info;
    logic                   head_skip;
    logic [7:0]             head_alen;
    logic                   at_alen, at_end;
    logic                   collect_close, collect_err, drain_close, overflow;
    logic                   txn_push, beat, idle_go, row_pop;
    logic                   push_skip, push_collect, push_drain, row_push;
    logic [BW_ROW-1:0]      asm_merged, push_data;
    logic                   push_err;

    assign active     = enable & ~rst;
    assign desc_empty = (desc_cnt_q == '0);
    assign desc_full  = (desc_cnt_q == CntW'(NUM_ENTRY));
    assign out_empty  = (out_cnt_q == '0);
    assign out_full   = (out_cnt_q == CntW'(NUM_ENTRY));

    assign head_info = desc_mem[desc_rd_q];
    assign head_skip = head_info[BW_TXN_INFO-1];
    assign head_alen = head_info[BW_BITADDR +: 8];

    assign txn_ready = active & ~desc_full;
    assign rready    = active & (state_q != StIdle);
    assign row_valid = active & ~out_empty;

    assign txn_push = txn_valid & txn_ready;
    assign beat     = rvalid & rready;
    assign row_pop  = row_valid & row_ready;
    // Output space is reserved here, so a later row push can never be blocked.
    assign idle_go  = active & (state_q == StIdle) & ~desc_empty & ~out_full;

    // beat_cnt_q is the index of the beat currently on the bus within this row.
    assign at_alen = (beat_cnt_q == head_alen);
    assign at_end  = (beat_cnt_q == 8'(MAX_NUM_AXI_DATA - 1));

`ifdef DCA_RROW_ASSEMBLER_ERROR_EN
    assign collect_close = rlast;
    assign collect_err   = (rresp != 2'b00) | (rlast ^ at_alen) | (at_end & ~rlast);
    assign drain_close   = rlast;
`else
    assign collect_close = at_alen;
    assign collect_err   = at_end & ~at_alen;
    assign drain_close   = at_alen;
    logic unused_rsig;
    assign unused_rsig = ^{rlast, rresp};
`endif
    assign overflow = at_end & ~collect_close;

    always_comb begin
        asm_merged = asm_q;
        for (int k = 0; k < int'(MAX_NUM_AXI_DATA); k++) begin
            if (beat_cnt_q == 8'(k)) begin
                asm_merged[BW_AXI_DATA*k +: BW_AXI_DATA] = rdata;
            end
        end
    end

    assign push_skip    = idle_go & head_skip;
    assign push_collect = beat & (state_q == StCollect) & collect_close;
    assign push_drain   = beat & (state_q == StDrain) & drain_close;
    assign row_push     = push_skip | push_collect | push_drain;

    always_comb begin
        push_data = '0;
        push_err  = 1'b0;
        if (push_collect) begin
            push_data = asm_merged;
            push_err  = err_q | collect_err;
        end else if (push_drain) begin
            push_data = asm_q;
            push_err  = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            asm_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (idle_go && !head_skip) begin
                        asm_q      <= '0;
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                        state_q    <= StCollect;
                    end
                end
                StCollect: begin
                    if (beat) begin
                        asm_q      <= asm_merged;
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        err_q      <= err_q | collect_err;
                        if (collect_close) begin
                            state_q <= StIdle;
                        end else if (overflow) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (drain_close) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The head descriptor retires exactly when its row enters the output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_wr_q  <= '0;
            desc_rd_q  <= '0;
            desc_cnt_q <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            if (txn_push) desc_wr_q <= ptr_inc(desc_wr_q);
            if (row_push) desc_rd_q <= ptr_inc(desc_rd_q);
            if (txn_push && !row_push) begin
                desc_cnt_q <= desc_cnt_q + 1'b1;
            end else if (!txn_push && row_push) begin
                desc_cnt_q <= desc_cnt_q - 1'b1;
            end
            if (row_push) out_wr_q <= ptr_inc(out_wr_q);
            if (row_pop)  out_rd_q <= ptr_inc(out_rd_q);
            if (row_push && !row_pop) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end else if (!row_push && row_pop) begin
                out_cnt_q <= out_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (txn_push) begin
            desc_mem[desc_wr_q] <= txn_info;
        end
        if (row_push) begin
            row_mem[out_wr_q]  <= push_data;
            info_mem[out_wr_q] <= head_info;
        end
    end

    assign row_data = row_valid ? row_mem[out_rd_q] : '0;
    assign row_info = row_valid ? info_mem[out_rd_q] : '0;

`ifdef DCA_RROW_ASSEMBLER_ERROR_EN
    logic err_mem [NUM_ENTRY];

    always_ff @(posedge clk) begin
        if (row_push) begin
            err_mem[out_wr_q] <= push_err;
        end
    end

    assign row_error = row_valid & err_mem[out_rd_q];
`else
    logic unused_err;
    assign unused_err = push_err;
    assign row_error  = 1'b0;
`endif

endmodule

// File: tb/tb_dca_matrix_rrow_assembler.sv
// Scoreboard bench for dca_matrix_rrow_assembler; expected behaviour follows DCA_RROW_ASSEMBLER_ERROR_EN.
module tb_dca_matrix_rrow_assembler;

    localparam int W    = 32;
    localparam int MAXB = 4;
    localparam int BA   = 32;
    localparam int NE   = 2;
    localparam int ROW  = W * MAXB;
    localparam int TI   = 2 + 8 + BA;

    logic           clk = 1'b0;
    logic           rst, enable, txn_valid, txn_ready;
    logic [TI-1:0]  txn_info;
    logic           rvalid, rlast, rready;
    logic [1:0]     rresp;
    logic [W-1:0]   rdata;
    logic           row_valid, row_ready, row_error;
    logic [ROW-1:0] row_data;
    logic [TI-1:0]  row_info;

    always #5 clk = ~clk;

    dca_matrix_rrow_assembler #(
        .BW_AXI_DATA     (W),
        .MAX_NUM_AXI_DATA(MAXB),
        .BW_BITADDR      (BA),
        .NUM_ENTRY       (NE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .txn_valid(txn_valid),
        .txn_info (txn_info),
        .txn_ready(txn_ready),
        .rvalid   (rvalid),
        .rlast    (rlast),
        .rresp    (rresp),
        .rdata    (rdata),
        .rready   (rready),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_data (row_data),
        .row_info (row_info),
        .row_error(row_error)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   resp;
    } beat_t;

    typedef struct packed {
        logic [ROW-1:0] data;
        logic [TI-1:0]  info;
        logic           err;
    } row_t;

    beat_t        beat_q[$];
    row_t         exp_q[$];
    logic [W-1:0] bd [8];
    logic [1:0]   br [8];
    int           errors = 0;
    int           checks = 0;
    int           rr_mode = 2;  // 0 random, 1 hold low, 2 hold high, 3 one-cycle pulse

    task automatic chk(input string name, input logic [ROW-1:0] act, input logic [ROW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [TI-1:0] mk_info(input bit skip, input bit lastrow, input int alen,
                                              input logic [BA-1:0] addr);
        return {skip, lastrow, 8'(alen), addr};
    endfunction

    // Reference model: a row holds the first MAXB beats in order, zeros elsewhere.
    task automatic issue(input logic [TI-1:0] info, input int n);
        row_t e;
        int   alen;
        bit   anyr;
        alen   = int'(info[BA +: 8]);
        e.data = '0;
        e.info = info;
        anyr   = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k < MAXB) e.data[k*W +: W] = bd[k];
            if (br[k] != 2'b00) anyr = 1'b1;
            beat_q.push_back('{data: bd[k], last: (k == n - 1), resp: br[k]});
        end
`ifdef DCA_RROW_ASSEMBLER_ERROR_EN
        e.err = !info[TI-1] && (anyr || (n != alen + 1) || (n > MAXB));
`else
        e.err = 1'b0;
`endif
        exp_q.push_back(e);
        send_desc(info);
    endtask

    task automatic send_desc(input logic [TI-1:0] info);
        int waited = 0;
        @(negedge clk);
        txn_valid = 1'b1;
        txn_info  = info;
        #4;
        while (!txn_ready) begin
            waited++;
            if (waited > 500) begin
                checks++;
                errors++;
                $display("FAIL txn_accept: txn_ready got 0 expected 1");
                break;
            end
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        txn_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_q.size() != 0 || beat_q.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: pending rows %0d beats %0d expected 0 0",
                     exp_q.size(), beat_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // R channel driver: presents queued beats with random bubbles, junk when idle.
    initial begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            if (beat_q.size() > 0 && $urandom_range(3) != 0) begin
                rvalid = 1'b1;
                rdata  = beat_q[0].data;
                rlast  = beat_q[0].last;
                rresp  = beat_q[0].resp;
            end else begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rlast  = 1'($urandom_range(1));
                rresp  = 2'($urandom_range(3));
            end
            #4;
            if (rvalid && rready) void'(beat_q.pop_front());
        end
    end

    initial begin
        row_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       row_ready = 1'($urandom_range(1));
                1:       row_ready = 1'b0;
                3: begin row_ready = 1'b1; rr_mode = 1; end
                default: row_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every accepted row is compared against the scoreboard head.
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            #4;
            if (row_valid && row_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got row info %0h expected none", row_info);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_data", row_data, e.data);
                    chk("row_info", ROW'(row_info), ROW'(e.info));
                    chk("row_error", ROW'(row_error), ROW'(e.err));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, alen, rdy_cnt, c;
        bit skip;
        rst = 1'b1; enable = 1'b1; txn_valid = 1'b0; txn_info = '0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_txn_ready", ROW'(txn_ready), ROW'(0));
        chk("rst_rready", ROW'(rready), ROW'(0));
        chk("rst_row_valid", ROW'(row_valid), ROW'(0));
        chk("rst_row_data", row_data, '0);
        chk("rst_row_info", ROW'(row_info), ROW'(0));
        chk("rst_row_error", ROW'(row_error), ROW'(0));
        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("post_rst_txn_ready", ROW'(txn_ready), ROW'(1));

        // Full row, then a short row that must leave upper slots zero.
        for (int k = 0; k < 4; k++) begin bd[k] = 32'hA0 + 32'(k); br[k] = 2'b00; end
        issue(mk_info(0, 0, 3, 32'h1000), 4);
        bd[0] = 32'h11; bd[1] = 32'h22; br[0] = 2'b00; br[1] = 2'b00;
        issue(mk_info(0, 1, 1, 32'h2000), 2);
        // Overlong burst: four stored, four discarded.
        for (int k = 0; k < 8; k++) begin bd[k] = 32'h70 + 32'(k); br[k] = 2'b00; end
        issue(mk_info(0, 0, 7, 32'h3000), 8);
`ifdef DCA_RROW_ASSEMBLER_ERROR_EN
        bd[0] = 32'hB0; bd[1] = 32'hB1; br[0] = 2'b00; br[1] = 2'b00;
        issue(mk_info(0, 0, 3, 32'h4000), 2);
        for (int k = 0; k < 4; k++) begin bd[k] = 32'hC0 + 32'(k); br[k] = 2'b00; end
        br[1] = 2'b10;
        issue(mk_info(0, 0, 3, 32'h5000), 4);
`endif
        wait_idle();

        // Skip descriptor: zero row without touching the R channel.
        rdy_cnt = 0;
        issue(mk_info(1, 1, 2, 32'hDEAD_BEEF), 0);
        repeat (8) begin
            @(negedge clk);
            #4;
            if (rready) rdy_cnt++;
        end
        chk("skip_no_rready", ROW'(rdy_cnt), ROW'(0));
        wait_idle();

        // Output FIFO full: third descriptor must wait in IDLE.
        rr_mode = 1;
        for (int i = 0; i < 3; i++) begin
            bd[0] = 32'hE0 + 32'(i); br[0] = 2'b00;
            issue(mk_info(0, 0, 0, 32'(i * 16)), 1);
        end
        repeat (20) @(negedge clk);
        #4;
        chk("stall_row_valid", ROW'(row_valid), ROW'(1));
        chk("stall_rready", ROW'(rready), ROW'(0));
        chk("stall_beat_held", ROW'(beat_q.size()), ROW'(1));
        rr_mode = 3;
        repeat (20) @(negedge clk);
        chk("restart_beat_taken", ROW'(beat_q.size()), ROW'(0));
        rr_mode = 2;
        wait_idle();

        // enable=0 masks all handshakes even with a row waiting.
        rr_mode = 1;
        bd[0] = 32'h5A5A_0001; br[0] = 2'b00;
        issue(mk_info(0, 1, 0, 32'h77), 1);
        c = 0;
        while (!row_valid && c < 100) begin @(negedge clk); #4; c++; end
        chk("en_row_waiting", ROW'(row_valid), ROW'(1));
        @(negedge clk);
        enable = 1'b0;
        #4;
        chk("en0_row_valid", ROW'(row_valid), ROW'(0));
        chk("en0_txn_ready", ROW'(txn_ready), ROW'(0));
        chk("en0_rready", ROW'(rready), ROW'(0));
        @(negedge clk);
        enable = 1'b1;
        rr_mode = 2;
        wait_idle();

        // Reset in the middle of a row: partial row discarded.
        bd[0] = 32'h99; bd[1] = 32'h98;
        beat_q.push_back('{data: bd[0], last: 1'b0, resp: 2'b00});
        beat_q.push_back('{data: bd[1], last: 1'b0, resp: 2'b00});
        send_desc(mk_info(0, 0, 3, 32'h8000));
        c = 0;
        while (beat_q.size() != 0 && c < 100) begin @(negedge clk); c++; end
        chk("partial_beats_taken", ROW'(beat_q.size()), ROW'(0));
        @(negedge clk);
        rst = 1'b1;
        #4;
        chk("midrst_txn_ready", ROW'(txn_ready), ROW'(0));
        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("midrst_rready", ROW'(rready), ROW'(0));
        chk("midrst_row_valid", ROW'(row_valid), ROW'(0));
        bd[0] = 32'h11; bd[1] = 32'h22; br[0] = 2'b00; br[1] = 2'b00;
        issue(mk_info(0, 0, 1, 32'h9000), 2);
        wait_idle();

        // Randomized traffic with random consumer back-pressure.
        rr_mode = 0;
        for (int i = 0; i < 60; i++) begin
            skip = ($urandom_range(4) == 0);
            alen = $urandom_range(6);
            n = 0;
            if (!skip) begin
`ifdef DCA_RROW_ASSEMBLER_ERROR_EN
                n = ($urandom_range(3) == 0) ? $urandom_range(7, 1) : alen + 1;
`else
                n = alen + 1;
`endif
                for (int k = 0; k < n; k++) begin
                    bd[k] = $urandom;
`ifdef DCA_RROW_ASSEMBLER_ERROR_EN
                    br[k] = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
`else
                    br[k] = 2'($urandom_range(3));
`endif
                end
            end
            issue(mk_info(skip, 1'($urandom_range(1)), alen, $urandom), n);
        end
        rr_mode = 2;
        wait_idle();
        #4;
        chk("final_row_valid", ROW'(row_valid), ROW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
